// File: rtl/pat_det_pkg.sv
// Shared state encoding, detected pattern and default sizing for the
// pattern-detector scheduler.
package pat_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam int                PAT_LEN = 4;
  localparam logic [PAT_LEN-1:0] PATTERN = 4'b1011;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_FRAME_LEN = 16;
  localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/pat_det_core.sv
// Overlapping Moore detector for PATTERN: the last PAT_LEN accepted bits are
// the state, so every window is tested and matches may share bits.
module pat_det_core
  import pat_det_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic valid_i,
  input  logic d_i,
  output logic det_o
);

  logic [PAT_LEN-1:0] hist_reg;

  // Clearing to zero cannot fake a match because the pattern's oldest bit is 1.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      hist_reg <= '0;
    end else if (clr_i) begin
      hist_reg <= '0;
    end else if (valid_i) begin
      hist_reg <= {hist_reg[PAT_LEN-2:0], d_i};
    end
  end

  assign det_o = (hist_reg == PATTERN);

endmodule

// File: rtl/pat_det_sched.sv
// Round-robin scheduler sharing one "1011" detector across NUM_REQ serial
// requesters. Define PAT_DET_SCHED_STATS_EN to build the cumulative match total.
module pat_det_sched
  import pat_det_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         d_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(NUM_REQ)-1:0] done_id_o,
  output logic [CNT_W-1:0]           match_cnt_o,
  output logic [15:0]                total_match_o
);

  localparam int               IDX_W     = $clog2(NUM_REQ);
  localparam logic [7:0]       LAST_BEAT = 8'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic               start;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [NUM_REQ-1:0] sel_onehot;
  logic [7:0]         beat_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               det;

  // Search starts one past the last granted requester.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    sel_idx   = ptr_reg;
    sel_found = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(ptr_reg) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!sel_found && req_i[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign sel_onehot[gi] = (sel_idx == IDX_W'(gi));
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_i) begin
          state_next = STREAM;
          start      = 1'b1;
        end
      end
      STREAM:  if (beat_reg == LAST_BEAT) state_next = FLUSH;
      FLUSH:   state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
      ptr_reg   <= IDX_LAST;
      gnt_reg   <= '0;
      beat_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        ptr_reg  <= sel_idx;
        gnt_reg  <= sel_onehot;
        beat_reg <= '0;
        cnt_reg  <= '0;
      end else begin
        if (state_reg == STREAM) begin
          beat_reg <= beat_reg + 8'd1;
          if (beat_reg == LAST_BEAT) gnt_reg <= '0;
        end
        // FLUSH still counts so a match closed by the final bit is kept.
        if ((state_reg == STREAM || state_reg == FLUSH) && det && cnt_reg != CNT_MAX)
          cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  pat_det_core u_core (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (start),
    .valid_i (state_reg == STREAM),
    .d_i     (d_i[ptr_reg]),
    .det_o   (det)
  );

  assign gnt_o       = gnt_reg;
  assign busy_o      = (state_reg != IDLE);
  assign done_o      = (state_reg == REPORT);
  assign done_id_o   = done_o ? ptr_reg : '0;
  assign match_cnt_o = done_o ? cnt_reg : '0;

`ifdef PAT_DET_SCHED_STATS_EN
  logic [15:0] total_reg;
  logic [16:0] total_sum;

  assign total_sum = {1'b0, total_reg} + 17'(cnt_reg);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      total_reg <= '0;
    end else if (state_reg == REPORT) begin
      total_reg <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end
  end

  assign total_match_o = total_reg;
`else
  assign total_match_o = '0;
`endif

endmodule

// File: tb/tb_pat_det_sched.sv
// Self-checking bench for pat_det_sched: reset, table vectors, random frames
// against a frame-level model, abort and statistics sequences.
module tb_pat_det_sched;

  localparam int NUM_REQ   = 4;
  localparam int FRAME_LEN = 16;
  localparam int CNT_W     = 8;
`ifdef PAT_DET_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] d_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic               busy_o;
  logic               done_o;
  logic [1:0]         done_id_o;
  logic [CNT_W-1:0]   match_cnt_o;
  logic [15:0]        total_match_o;

  int checks   = 0;
  int failures = 0;
  int last_gnt = NUM_REQ - 1;
  int exp_total = 0;

  always #5 clk_i = ~clk_i;

  pat_det_sched #(
    .NUM_REQ   (NUM_REQ),
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .d_i           (d_i),
    .gnt_o         (gnt_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .done_id_o     (done_id_o),
    .match_cnt_o   (match_cnt_o),
    .total_match_o (total_match_o)
  );

  typedef struct {
    logic [3:0]  req;
    logic [15:0] bits;
    bit          drop;
    int          exp_id;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: round-robin pick starting after the last grant.
  function automatic int model_pick(input logic [3:0] req, input int last);
    int c;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = (last + i) % NUM_REQ;
      if (req[c[1:0]]) return c;
    end
    return -1;
  endfunction

  // Reference: count every 4-bit window of the frame (time order MSB first).
  function automatic int model_count(input logic [15:0] bits);
    int n = 0;
    logic [3:0] w;
    for (int p = 0; p + 4 <= FRAME_LEN; p++) begin
      w = bits[15-p -: 4];
      if (w == 4'b1011) n++;
    end
    return (n > 255) ? 255 : n;
  endfunction

  // Entered at a negedge with the DUT idle; leaves at the negedge after REPORT.
  task automatic run_frame(input logic [3:0] req, input logic [15:0] bits, input bit drop,
                           input int exp_id, input int exp_cnt, input string name);
    int         bad_gnt = 0;
    int         early_done = 0;
    logic [3:0] exp_oh;
    logic [3:0] d_rand;
    exp_oh = 4'b0001 << exp_id;
    req_i  = req;
    for (int k = 0; k < FRAME_LEN; k++) begin
      @(negedge clk_i);
      if (k == 0) check({name, "_gnt_first"}, gnt_o, exp_oh);
      if (gnt_o !== exp_oh || busy_o !== 1'b1) bad_gnt++;
      if (done_o !== 1'b0) early_done++;
      d_rand         = 4'($urandom);
      d_rand[exp_id] = bits[15-k];
      d_i            = d_rand;
      if (drop && k == 4) req_i = '0;
    end
    check({name, "_gnt_hold"}, bad_gnt, 0);
    @(negedge clk_i);
    if (done_o !== 1'b0) early_done++;
    check({name, "_flush_gnt"}, gnt_o, 0);
    check({name, "_flush_busy"}, busy_o, 1);
    check({name, "_early_done"}, early_done, 0);
    @(negedge clk_i);
    check({name, "_done"}, done_o, 1);
    check({name, "_done_id"}, done_id_o, exp_id);
    check({name, "_match_cnt"}, match_cnt_o, exp_cnt);
    last_gnt = exp_id;
    if (STATS) exp_total = (exp_total + exp_cnt > 65535) ? 65535 : exp_total + exp_cnt;
    @(negedge clk_i);
    check({name, "_idle_busy"}, busy_o, 0);
    check({name, "_idle_done"}, done_o, 0);
    check({name, "_total"}, total_match_o, exp_total);
    $display("frame %s req=%b bits=%h id=%0d cnt=%0d total=%0d",
             name, req, bits, done_id_o, exp_cnt, total_match_o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  r_req;
    logic [15:0] r_bits;
    bit          r_drop;

    vecs[0] = '{4'b0001, 16'hB6D8, 1'b0, 0, 4};
    vecs[1] = '{4'b1111, 16'h0000, 1'b0, 1, 0};
    vecs[2] = '{4'b1111, 16'hFFFF, 1'b0, 2, 0};
    vecs[3] = '{4'b1111, 16'h000B, 1'b0, 3, 1};
    vecs[4] = '{4'b1111, 16'hB6D8, 1'b0, 0, 4};
    vecs[5] = '{4'b1001, 16'hBBBB, 1'b1, 3, 4};
    vecs[6] = '{4'b0100, 16'h2D2D, 1'b0, 2, 2};
    vecs[7] = '{4'b0011, 16'hDDDD, 1'b0, 0, 3};

    rst_i = 1'b0;
    req_i = 4'b1111;
    d_i   = 4'b1111;
    repeat (2) @(negedge clk_i);
    check("reset_gnt", gnt_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_done_id", done_id_o, 0);
    check("reset_match_cnt", match_cnt_o, 0);
    check("reset_total", total_match_o, 0);
    $display("reset held 2 cycles busy=%0b gnt=%b", busy_o, gnt_o);
    rst_i = 1'b1;
    req_i = '0;
    d_i   = '0;
    @(negedge clk_i);
    check("post_reset_busy", busy_o, 0);

    for (int i = 0; i < 8; i++)
      run_frame(vecs[i].req, vecs[i].bits, vecs[i].drop, vecs[i].exp_id,
                vecs[i].exp_cnt, $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++) begin
      r_req  = 4'($urandom_range(1, 15));
      r_bits = 16'($urandom);
      r_drop = 1'($urandom_range(0, 1));
      run_frame(r_req, r_bits, r_drop, model_pick(r_req, last_gnt),
                model_count(r_bits), $sformatf("rnd%0d", i));
    end

    // Abort: reset after the 8th streamed bit of a requester-0 frame.
    req_i = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      d_i = {4{k[0]}};
    end
    @(negedge clk_i);
    check("abort_pre_gnt", gnt_o, 4'b0001);
    rst_i = 1'b0;
    req_i = 4'b0110;
    @(negedge clk_i);
    check("abort_gnt", gnt_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_total", total_match_o, 0);
    $display("abort reset applied gnt=%b done=%0b", gnt_o, done_o);
    rst_i     = 1'b1;
    last_gnt  = NUM_REQ - 1;
    exp_total = 0;
    run_frame(4'b0110, 16'hB6D8, 1'b0, 1, 4, "abort_next");
    run_frame(4'b0110, 16'hB6D8, 1'b0, 2, 4, "stats_second");
    check("stats_total", total_match_o, STATS ? 8 : 0);

    req_i = '0;
    @(negedge clk_i);
    check("final_idle", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
